lsu_mem_stage: RTL

- Load/store unit in the MEM stage, directly upstream of the byte-lane data memory.
- Takes the EX/MEM request (read/write, funct3, address, store data) and drives the memory's address, write-enable, write data and 4-bit ByteEn.
- Returns load data to MEM/WB.
- Misaligned accesses are split into sequential single-byte accesses; the pipeline is stalled while the split runs.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_load_extend.sv | 23 ++
 rtl/lsu_mem_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the MEM-stage load/store unit.
package lsu_pkg;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_W    = 4'b1111;
    localparam logic [3:0] BE_BU   = 4'b0001;
    localparam logic [3:0] BE_B    = 4'b1001;
    localparam logic [3:0] BE_HU   = 4'b0011;
    localparam logic [3:0] BE_H    = 4'b1011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } lsu_state_e;

    // Stores only ever use the zero-extending encodings; the memory ignores extension on writes.
    function automatic logic [3:0] byteen_for(input logic [2:0] f3, input logic is_store);
        logic [3:0] be;
        be = BE_NONE;
        if (is_store) begin
            case (f3[1:0])
                2'b00:   be = BE_BU;
                2'b01:   be = BE_HU;
                2'b10:   be = BE_W;
                default: be = BE_NONE;
            endcase
        end else begin
            case (f3)
                F3_B:    be = BE_B;
                F3_BU:   be = BE_BU;
                F3_H:    be = BE_H;
                F3_HU:   be = BE_HU;
                F3_W:    be = BE_W;
                default: be = BE_NONE;
            endcase
        end
        return be;
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of bytes assembled by a split load.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] bytes_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    // Select the extension from the captured load size.
    always_comb begin
        data_o = 32'h0000_0000;
        case (funct3_i)
            F3_B:    data_o = {{24{bytes_i[7]}}, bytes_i[7:0]};
            F3_BU:   data_o = {24'h00_0000, bytes_i[7:0]};
            F3_H:    data_o = {{16{bytes_i[15]}}, bytes_i[15:0]};
            F3_HU:   data_o = {16'h0000, bytes_i[15:0]};
            F3_W:    data_o = bytes_i;
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: drives the byte-lane data memory and splits
// misaligned halfword/word accesses into sequential byte accesses.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] dmem_a_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_wd_o,
    output logic [3:0]  dmem_byteen_o,
    input  logic [31:0] dmem_rd_i,
    output logic [31:0] load_data_o,
    output logic        stall_o,
    output logic        access_fault_o
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] cap_addr_q, cap_addr_d;
    logic [2:0]  cap_funct3_q, cap_funct3_d;
    logic [31:0] cap_wdata_q, cap_wdata_d;
    logic        cap_store_q, cap_store_d;
    logic [31:0] ld_buf_q, ld_buf_d;

    logic        req_s;
    logic        misaligned_s;
    logic        illegal_s;
    logic        last_s;
    logic [4:0]  lane_s;
    logic [31:0] assembled_s;
    logic [31:0] extended_s;

    // Request classification in IDLE.
    always_comb begin
        req_s        = mem_read_i | mem_write_i;
        misaligned_s = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                       ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        illegal_s    = req_s && ((mem_read_i && mem_write_i) ||
                                 !f3_legal(funct3_i, mem_write_i) ||
                                 (misaligned_s && !ALLOW_MISALIGNED));
    end

    // Merge the byte returning this cycle into the partially captured load.
    always_comb begin
        lane_s      = {cnt_q, 3'b000};
        last_s      = (cap_funct3_q[1:0] == 2'b10) ? (cnt_q == 2'd3) : (cnt_q == 2'd1);
        assembled_s = ld_buf_q;
        assembled_s[lane_s +: 8] = dmem_rd_i[7:0];
    end

    lsu_load_extend u_load_extend (
        .bytes_i  (assembled_s),
        .funct3_i (cap_funct3_q),
        .data_o   (extended_s)
    );

    // Next-state and memory-side outputs; everything is forced low while reset is high.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cap_addr_d     = cap_addr_q;
        cap_funct3_d   = cap_funct3_q;
        cap_wdata_d    = cap_wdata_q;
        cap_store_d    = cap_store_q;
        ld_buf_d       = ld_buf_q;
        dmem_a_o       = 32'h0000_0000;
        dmem_we_o      = 1'b0;
        dmem_wd_o      = 32'h0000_0000;
        dmem_byteen_o  = BE_NONE;
        load_data_o    = 32'h0000_0000;
        stall_o        = 1'b0;
        access_fault_o = 1'b0;
        if (reset) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    dmem_a_o = addr_i;
                    if (illegal_s) begin
                        access_fault_o = 1'b1;
                    end else if (req_s && misaligned_s) begin
                        dmem_byteen_o = BE_BU;
                        dmem_we_o     = mem_write_i;
                        dmem_wd_o     = {24'h00_0000, wdata_i[7:0]};
                        stall_o       = 1'b1;
                        cap_addr_d    = addr_i;
                        cap_funct3_d  = funct3_i;
                        cap_wdata_d   = wdata_i;
                        cap_store_d   = mem_write_i;
                        ld_buf_d      = mem_write_i ? 32'h0000_0000
                                                    : {24'h00_0000, dmem_rd_i[7:0]};
                        cnt_d         = 2'd1;
                        state_d       = SPLIT;
                    end else if (req_s) begin
                        dmem_byteen_o = byteen_for(funct3_i, mem_write_i);
                        dmem_we_o     = mem_write_i;
                        dmem_wd_o     = wdata_i;
                        load_data_o   = mem_read_i ? dmem_rd_i : 32'h0000_0000;
                    end else begin
                        dmem_byteen_o = BE_NONE;
                    end
                end
                SPLIT: begin
                    dmem_a_o      = cap_addr_q + {30'h0000_0000, cnt_q};
                    dmem_byteen_o = BE_BU;
                    dmem_we_o     = cap_store_q;
                    dmem_wd_o     = {24'h00_0000, cap_wdata_q[lane_s +: 8]};
                    if (cap_store_q) begin
                        ld_buf_d = ld_buf_q;
                    end else begin
                        ld_buf_d = assembled_s;
                    end
                    if (last_s) begin
                        state_d     = IDLE;
                        cnt_d       = 2'd0;
                        load_data_o = cap_store_q ? 32'h0000_0000 : extended_s;
                    end else begin
                        stall_o = 1'b1;
                        cnt_d   = cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // State and captured-request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            cap_addr_q   <= 32'h0000_0000;
            cap_funct3_q <= 3'b000;
            cap_wdata_q  <= 32'h0000_0000;
            cap_store_q  <= 1'b0;
            ld_buf_q     <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_addr_q   <= cap_addr_d;
            cap_funct3_q <= cap_funct3_d;
            cap_wdata_q  <= cap_wdata_d;
            cap_store_q  <= cap_store_d;
            ld_buf_q     <= ld_buf_d;
        end
    end

endmodule
